// File: rtl/pcm_framer.sv
// Multi-channel PCM front end: pre-emphasis, a circular sample buffer, and
// overlapping frames zero-padded to NFFT on a ready/valid stream.
module pcm_framer #(
  parameter int          SAMPLE_WIDTH   = 16,
  parameter int          NUM_CHANNELS   = 1,
  parameter int          NFFT           = 512,
  parameter int          FRAME_SIZE_MAX = 400,
  parameter int          BUF_DEPTH      = 1024,
  parameter logic [15:0] ALPHA          = 16'd31785
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]   pcm_in,
  input  logic                                   pcm_ready_i,
  input  logic [$clog2(FRAME_SIZE_MAX+1)-1:0]    frame_size_i,
  input  logic [$clog2(FRAME_SIZE_MAX+1)-1:0]    frame_move_i,
  input  logic                                   pre_emph_en_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]   out_data_o,
  output logic [$clog2(NFFT)-1:0]                frame_ptr_o,
  output logic                                   frame_last_o,
  output logic                                   overrun_o,
  output logic [15:0]                            drop_count_o
);
  localparam int DW = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int FW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(FRAME_SIZE_MAX + 1);
  localparam int PW = $clog2(NFFT);
  localparam int KW = $clog2(NFFT + 1);

  typedef enum logic [1:0] {IDLE, EMIT, PAD, ADVANCE} state_t;

  function automatic logic signed [SAMPLE_WIDTH-1:0] sat(input logic signed [SAMPLE_WIDTH:0] d);
    if (d[SAMPLE_WIDTH] != d[SAMPLE_WIDTH-1])
      sat = d[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else
      sat = d[SAMPLE_WIDTH-1:0];
  endfunction

  function automatic logic signed [SAMPLE_WIDTH-1:0] pre_emph(
    input logic signed [SAMPLE_WIDTH-1:0] x,
    input logic signed [SAMPLE_WIDTH-1:0] xp
  );
    logic signed [31:0] a32, xp32, x32, prod, sh;
    logic signed [SAMPLE_WIDTH:0] d;
    a32  = 32'(ALPHA);
    xp32 = 32'(xp);
    x32  = 32'(x);
    prod = a32 * xp32;
    sh   = prod >>> 15;
    d    = (SAMPLE_WIDTH+1)'(x32 - sh);
    pre_emph = sat(d);
  endfunction

  logic [DW-1:0] pe_data_p0;
  logic          vld_p0;
  logic [DW-1:0] x_prev;
  logic [DW-1:0] mem [BUF_DEPTH];
  logic [AW-1:0] wp, rb, rd_addr;
  logic [FW-1:0] fill;
  logic [CW-1:0] fs_c, hop_c, fs_q, hop_q;
  logic [KW-1:0] ik;
  state_t        state, state_nxt;
  logic          full, accept, adv, acc, issue;

  always_comb begin
    fs_c = frame_size_i;
    if (frame_size_i == '0)                      fs_c = CW'(1);
    else if (32'(frame_size_i) > FRAME_SIZE_MAX) fs_c = CW'(FRAME_SIZE_MAX);
    hop_c = frame_move_i;
    if (frame_move_i == '0)      hop_c = CW'(1);
    else if (frame_move_i > fs_c) hop_c = fs_c;
  end

  // A sample still in the pre-emphasis register already owns a buffer slot.
  assign full    = (32'(fill) + 32'(vld_p0)) >= BUF_DEPTH;
  assign accept  = pcm_ready_i && !full;
  assign adv     = !out_valid_o || out_ready_i;
  assign acc     = out_valid_o && out_ready_i;
  assign issue   = ((state == EMIT) || (state == PAD)) && (ik != KW'(NFFT)) && adv;
  assign rd_addr = rb + AW'(ik);

  // Stage p0: pre-emphasis register, then buffer write.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        pe_data_p0[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= pre_emph_en_i
          ? pre_emph(pcm_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH], x_prev[c*SAMPLE_WIDTH +: SAMPLE_WIDTH])
          : pcm_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    if (vld_p0) mem[wp] <= pe_data_p0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (32'(fill) >= 32'(fs_c)) state_nxt = EMIT;
      EMIT:    if (acc && (32'(frame_ptr_o) == 32'(fs_q) - 1))
                 state_nxt = (32'(fs_q) == NFFT) ? ADVANCE : PAD;
      PAD:     if (acc && frame_last_o) state_nxt = ADVANCE;
      ADVANCE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      x_prev       <= '0;
      overrun_o    <= 1'b0;
      drop_count_o <= '0;
      wp           <= '0;
      rb           <= '0;
      fill         <= '0;
      state        <= IDLE;
      fs_q         <= CW'(1);
      hop_q        <= CW'(1);
      ik           <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      frame_ptr_o  <= '0;
      frame_last_o <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) x_prev <= pcm_in;
      if (pcm_ready_i && full) begin
        overrun_o <= 1'b1;
        if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      end
      if (vld_p0) wp <= wp + AW'(1);
      fill <= fill + FW'(vld_p0) - ((state == ADVANCE) ? FW'(hop_q) : FW'(0));
      if (state == ADVANCE) rb <= rb + AW'(hop_q);
      state <= state_nxt;
      if (state == IDLE) begin
        ik <= '0;
        if (state_nxt == EMIT) begin
          fs_q  <= fs_c;
          hop_q <= hop_c;
        end
      end
      // Stage p1: synchronous buffer read straight into the output register.
      if (issue) begin
        out_valid_o  <= 1'b1;
        out_data_o   <= (32'(ik) < 32'(fs_q)) ? mem[rd_addr] : '0;
        frame_ptr_o  <= PW'(ik);
        frame_last_o <= (32'(ik) == NFFT - 1);
        ik           <= ik + KW'(1);
      end else if (adv) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pcm_framer.sv
// Randomized bench for pcm_framer: a sample-list reference model predicts
// every frame beat from the framing rules and pre-emphasis arithmetic.
module tb_pcm_framer;
  localparam int SW = 16, NC = 2, NFFT = 32, FSM = 32, BD = 64;
  localparam int CW = $clog2(FSM + 1), PW = $clog2(NFFT);
  localparam longint ALPHA_T = 31785;

  logic                clk = 1'b0, rst_n = 1'b1;
  logic [NC*SW-1:0]    pcm_in = '0, out_data_o;
  logic                pcm_ready_i = 1'b0, pre_emph_en_i = 1'b0, out_ready_i = 1'b0;
  logic [CW-1:0]       frame_size_i = '0, frame_move_i = '0;
  logic                out_valid_o, frame_last_o, overrun_o;
  logic [PW-1:0]       frame_ptr_o;
  logic [15:0]         drop_count_o;

  pcm_framer #(.SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC), .NFFT(NFFT),
               .FRAME_SIZE_MAX(FSM), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_in(pcm_in), .pcm_ready_i(pcm_ready_i),
    .frame_size_i(frame_size_i), .frame_move_i(frame_move_i),
    .pre_emph_en_i(pre_emph_en_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .frame_ptr_o(frame_ptr_o), .frame_last_o(frame_last_o),
    .overrun_o(overrun_o), .drop_count_o(drop_count_o));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] yexp[$];
  int  xprev[NC];
  int  n_acc, cap, fs_m, hop_m, k_m, frames_seen, fs_strobe_cyc, last_acc_cyc;
  bit  pe_m, mon_en = 0, lat_en = 0, gap_en = 0, stall_prev, valid_prev;
  logic [31:0]   data_prev;
  logic [PW-1:0] ptr_prev;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pe_model(int x, int xp, bit en);
    longint d;
    if (!en) return x;
    d = longint'(x) - ((ALPHA_T * longint'(xp)) >>> 15);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return int'(d);
  endfunction

  task automatic model_accept(input logic [15:0] a, input logic [15:0] b);
    int xa, xb, ya, yb;
    logic [15:0] ha, hb;
    if (n_acc >= cap) return;
    xa = int'($signed(a));
    xb = int'($signed(b));
    ya = pe_model(xa, xprev[0], pe_m);
    yb = pe_model(xb, xprev[1], pe_m);
    ha = 16'(ya);
    hb = 16'(yb);
    yexp.push_back({hb, ha});
    xprev[0] = xa;
    xprev[1] = xb;
    n_acc++;
    if (n_acc == fs_m) fs_strobe_cyc = cyc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit send, input logic [15:0] a, input logic [15:0] b, input int rmode);
    tick();
    out_ready_i = (rmode == 2) ? 1'($urandom % 2) : 1'(rmode);
    pcm_ready_i = send;
    if (send) begin
      pcm_in = {b, a};
      model_accept(a, b);
    end
  endtask

  task automatic start_phase(input int fs, input int mv, input bit pe, input int cp);
    mon_en = 0;
    pcm_ready_i = 0;
    out_ready_i = 0;
    rst_n = 0;
    frame_size_i = CW'(fs);
    frame_move_i = CW'(mv);
    pre_emph_en_i = pe;
    tick();
    tick();
    rst_n = 1;
    fs_m  = (fs == 0) ? 1 : ((fs > FSM) ? FSM : fs);
    hop_m = (mv == 0) ? 1 : ((mv > fs_m) ? fs_m : mv);
    pe_m = pe;
    cap = cp;
    yexp.delete();
    xprev[0] = 0;
    xprev[1] = 0;
    n_acc = 0;
    k_m = 0;
    frames_seen = 0;
    stall_prev = 0;
    valid_prev = 0;
    mon_en = 1;
  endtask

  task automatic drain(input int rmode, input int exp_drops);
    int exp_frames, t;
    exp_frames = (n_acc >= fs_m) ? (n_acc - fs_m) / hop_m + 1 : 0;
    t = 0;
    while (!(frames_seen == exp_frames && k_m == 0) && t < 20000) begin
      step(0, 16'd0, 16'd0, rmode);
      t++;
    end
    repeat (NFFT + 8) step(0, 16'd0, 16'd0, rmode);
    check_val("frame_count", frames_seen, exp_frames);
    check_val("beat_residue", k_m, 0);
    check_val("overrun", overrun_o, exp_drops != 0);
    check_val("drop_count", drop_count_o, exp_drops);
  endtask

  always @(negedge clk) begin
    int s;
    logic [31:0] exp_d;
    if (mon_en) begin
      if (stall_prev) begin
        check_val("hold_valid", out_valid_o, 1);
        check_val("hold_data", out_data_o, data_prev);
        check_val("hold_ptr", frame_ptr_o, ptr_prev);
      end
      if (out_valid_o && !valid_prev && k_m == 0) begin
        if (frames_seen == 0 && lat_en) check_val("first_latency", cyc - fs_strobe_cyc, 4);
        if (frames_seen > 0 && gap_en)  check_val("frame_gap", cyc - last_acc_cyc, 4);
      end
      if (out_valid_o && out_ready_i) begin
        s = frames_seen * hop_m;
        if (k_m == 0) check_val("frame_has_data", (s + fs_m) <= n_acc, 1);
        exp_d = '0;
        if (k_m < fs_m && (s + k_m) < n_acc) exp_d = yexp[s + k_m];
        check_val("ptr", frame_ptr_o, k_m);
        check_val("last", frame_last_o, k_m == NFFT - 1);
        check_val("data", out_data_o, exp_d);
        k_m++;
        if (k_m == NFFT) begin
          k_m = 0;
          frames_seen++;
          last_acc_cyc = cyc;
        end
      end
      valid_prev = out_valid_o;
      stall_prev = out_valid_o && !out_ready_i;
      data_prev  = out_data_o;
      ptr_prev   = frame_ptr_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sent, t;
    #2 rst_n = 0;
    #10;
    check_val("rst_valid", out_valid_o, 0);
    check_val("rst_data", out_data_o, 0);
    check_val("rst_ptr", frame_ptr_o, 0);
    check_val("rst_last", frame_last_o, 0);
    check_val("rst_overrun", overrun_o, 0);
    check_val("rst_drops", drop_count_o, 0);

    // Ramp, bypass, continuous ready; checks first-beat latency.
    start_phase(20, 8, 0, 1000);
    lat_en = 1;
    for (int i = 0; i < 60; i++) step(1, 16'(i), 16'(500 - 3 * i), 1);
    drain(1, 0);
    lat_en = 0;

    // Frame size equal to NFFT: no padding, fixed inter-frame gap.
    start_phase(32, 8, 0, 1000);
    gap_en = 1;
    for (int i = 0; i < 60; i++) step(1, 16'($urandom), 16'($urandom), 1);
    drain(1, 0);
    gap_en = 0;

    // Pre-emphasis with a constant, then a full-scale swing that saturates.
    start_phase(10, 10, 1, 1000);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = (i < 5) ? 16'sd1000 : (i == 5) ? 16'h7FFF : (i == 6) ? 16'h8000 : 16'($urandom);
      step(1, a, 16'($urandom), 1);
    end
    drain(1, 0);

    // Zero size and hop clamp to one.
    start_phase(0, 0, 0, 1000);
    for (int i = 0; i < 6; i++) step(1, 16'(i + 7), 16'(100 - i), 1);
    drain(1, 0);

    // Random configuration, sparse input and random back-pressure.
    for (int r = 0; r < 4; r++) begin
      start_phase(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'($urandom % 2), 1000);
      n = int'($urandom_range(20, 60));
      sent = 0;
      while (sent < n) begin
        if ($urandom % 2) begin
          step(1, 16'($urandom), 16'($urandom), 2);
          sent++;
        end else begin
          step(0, 16'd0, 16'd0, 2);
        end
      end
      drain(2, 0);
    end

    // Overrun with the output fully stalled.
    start_phase(16, 16, 0, BD);
    for (int i = 0; i < 80; i++) step(1, 16'(i), 16'(1000 + i), 0);
    step(0, 16'd0, 16'd0, 0);
    step(0, 16'd0, 16'd0, 0);
    check_val("overrun_stalled", overrun_o, 1);
    check_val("drops_stalled", drop_count_o, 80 - BD);
    drain(1, 80 - BD);

    // Reset in the middle of a frame, then a fresh stream.
    start_phase(16, 4, 0, 1000);
    for (int i = 0; i < 20; i++) step(1, 16'(i), 16'(i + 50), 0);
    t = 0;
    while (!out_valid_o && t < 50) begin
      step(0, 16'd0, 16'd0, 0);
      t++;
    end
    check_val("midframe_valid", out_valid_o, 1);
    repeat (3) step(0, 16'd0, 16'd0, 1);
    tick();
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    check_val("mid_rst_valid", out_valid_o, 0);
    check_val("mid_rst_data", out_data_o, 0);
    check_val("mid_rst_ptr", frame_ptr_o, 0);
    check_val("mid_rst_last", frame_last_o, 0);
    start_phase(12, 5, 1, 1000);
    for (int i = 0; i < 30; i++) step(1, 16'(3000 + 7 * i), 16'(-200 - i), 1);
    drain(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
